// File: rtl/ysyx_220053_pkg.sv
// Shared types and constants for the ysyx_220053 instruction fetch unit.
package ysyx_220053_pkg;

  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_ACCESS   = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_VALID = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } ifu_state_t;

endpackage

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time over a
// 64-bit imem port and hands it to decode on a valid/ready handshake.
module ysyx_220053_ifu
  import ysyx_220053_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC,
  parameter int unsigned CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [63:0]      imem_addr,
  input  logic             imem_rvalid,
  input  logic [63:0]      imem_rdata,
  input  logic             imem_rerr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr_o,
  output logic [63:0]      pc_o,
  input  logic [63:0]      dnpc_i,
  input  logic             halt_i,
  output logic             fetch_fault,
  output logic [1:0]       fault_cause,
  output logic [CNT_W-1:0] fetch_cnt
);

  ifu_state_t       state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             req_valid_q, instr_valid_q, fault_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      ST_REQ: begin
        if (imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (imem_rerr) begin
            state_d = ST_FAULT;
            cause_d = FAULT_ACCESS;
          end else begin
            instr_d = pc_q[2] ? imem_rdata[63:32] : imem_rdata[31:0];
            state_d = ST_VALID;
          end
        end
      end
      ST_VALID: begin
        if (instr_ready) begin
          pc_d  = dnpc_i;
          cnt_d = cnt_q + CNT_W'(1);
          // Halt wins over a misaligned target.
          if (halt_i) begin
            state_d = ST_HALT;
          end else if (dnpc_i[1:0] != 2'b00) begin
            state_d = ST_FAULT;
            cause_d = FAULT_MISALIGN;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Handshake/flag outputs are registered from the next state so they track state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      cnt_q         <= '0;
      cause_q       <= FAULT_NONE;
      req_valid_q   <= 1'b1;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      cnt_q         <= cnt_d;
      cause_q       <= cause_d;
      req_valid_q   <= (state_d == ST_REQ);
      instr_valid_q <= (state_d == ST_VALID);
      fault_q       <= (state_d == ST_FAULT);
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = {pc_q[63:3], 3'b000};
  assign instr_valid    = instr_valid_q;
  assign instr_o        = instr_q;
  assign pc_o           = pc_q;
  assign fetch_fault    = fault_q;
  assign fault_cause    = cause_q;
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Self-checking bench for ysyx_220053_ifu: directed scenarios followed by
// randomized episodes checked against a transaction-level fetch model.
module tb_ysyx_220053_ifu;

  localparam logic [63:0] RPC = 64'h8000_0000;
  localparam logic [63:0] DW0 = 64'h00100093_00000413;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [63:0] imem_rdata;
  logic        imem_rerr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic [63:0] dnpc_i;
  logic        halt_i;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic [63:0] fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_220053_ifu #(.RESET_PC(RPC), .CNT_W(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .imem_rerr     (imem_rerr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .dnpc_i        (dnpc_i),
    .halt_i        (halt_i),
    .fetch_fault   (fetch_fault),
    .fault_cause   (fault_cause),
    .fetch_cnt     (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory image: the directed doubleword at the reset PC, a hash elsewhere.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == RPC) return DW0;
    return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0] + 32'h0001_0001};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    imem_req_ready = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 64'd0;
    imem_rerr      = 1'b0;
    instr_ready    = 1'b0;
    dnpc_i         = 64'd0;
    halt_i         = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a request, accept it, then answer one cycle later.
  task automatic serve_fetch(input logic [63:0] rd, input logic err, output logic [63:0] addr);
    int n;
    n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", 64'(imem_req_valid), 64'd1);
    addr = imem_addr;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = rd;
    imem_rerr      = err;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rerr   = 1'b0;
  endtask

  task automatic accept(input logic [63:0] np, input logic h);
    check_eq("acc_valid", 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    dnpc_i      = np;
    halt_i      = h;
    @(negedge clk);
    instr_ready = 1'b0;
    halt_i      = 1'b0;
  endtask

  // Random-phase model state.
  logic [63:0] m_pc, m_cnt, r_addr, w;
  logic [31:0] m_instr;
  logic [1:0]  m_cause;
  int          m_term;   // 0 running, 1 halted, 2 faulted
  logic        m_req, m_valid, waiting;
  int          lat, post, r;
  logic [63:0] a;

  initial begin
    rst = 1'b1;
    drive_idle();

    // Reset values and first request.
    @(negedge clk);
    check_eq("rst_req_valid", 64'(imem_req_valid), 64'd1);
    check_eq("rst_instr_valid", 64'(instr_valid), 64'd0);
    check_eq("rst_instr", 64'(instr_o), 64'd0);
    check_eq("rst_fault", 64'(fetch_fault), 64'd0);
    check_eq("rst_cause", 64'(fault_cause), 64'd0);
    check_eq("rst_cnt", fetch_cnt, 64'd0);
    check_eq("rst_pc", pc_o, RPC);
    rst = 1'b0;
    check_eq("first_req_valid", 64'(imem_req_valid), 64'd1);
    check_eq("first_addr", imem_addr, RPC);

    // Sequential fetch from one doubleword.
    serve_fetch(DW0, 1'b0, a);
    check_eq("seq0_addr", a, RPC);
    check_eq("seq0_instr", 64'(instr_o), 64'h0000_0413);
    check_eq("seq0_pc", pc_o, RPC);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 64'(instr_valid), 64'd1);
      check_eq("stall_instr", 64'(instr_o), 64'h0000_0413);
      check_eq("stall_pc", pc_o, RPC);
      check_eq("stall_noreq", 64'(imem_req_valid), 64'd0);
    end
    accept(RPC + 64'd4, 1'b0);
    check_eq("seq1_cnt", fetch_cnt, 64'd1);
    check_eq("seq1_req", 64'(imem_req_valid), 64'd1);
    serve_fetch(DW0, 1'b0, a);
    check_eq("seq1_addr", a, RPC);
    check_eq("seq1_instr", 64'(instr_o), 64'h0010_0093);
    check_eq("seq1_pc", pc_o, RPC + 64'd4);

    // Branch, then misaligned target.
    accept(64'h8000_0100, 1'b0);
    check_eq("br_cnt", fetch_cnt, 64'd2);
    serve_fetch(64'hDEAD_BEEF_1234_5678, 1'b0, a);
    check_eq("br_addr", a, 64'h8000_0100);
    check_eq("br_instr", 64'(instr_o), 64'h1234_5678);
    accept(64'h8000_0006, 1'b0);
    check_eq("mis_fault", 64'(fetch_fault), 64'd1);
    check_eq("mis_cause", 64'(fault_cause), 64'd2);
    check_eq("mis_pc", pc_o, 64'h8000_0006);
    check_eq("mis_cnt", fetch_cnt, 64'd3);
    repeat (3) @(negedge clk);
    check_eq("mis_noreq", 64'(imem_req_valid), 64'd0);
    check_eq("mis_novalid", 64'(instr_valid), 64'd0);

    // Reset while in WAIT, then an access error on the refetch.
    do_reset();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check_eq("wait_noreq", 64'(imem_req_valid), 64'd0);
    rst = 1'b1;
    #1;
    check_eq("arst_req", 64'(imem_req_valid), 64'd1);
    check_eq("arst_pc", pc_o, RPC);
    check_eq("arst_cnt", fetch_cnt, 64'd0);
    check_eq("arst_fault", 64'(fetch_fault), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    serve_fetch(DW0, 1'b1, a);
    check_eq("err_addr", a, RPC);
    check_eq("err_fault", 64'(fetch_fault), 64'd1);
    check_eq("err_cause", 64'(fault_cause), 64'd1);
    check_eq("err_pc", pc_o, RPC);
    repeat (3) @(negedge clk);
    check_eq("err_noreq", 64'(imem_req_valid), 64'd0);

    // Halt wins over a misaligned dnpc.
    do_reset();
    serve_fetch(DW0, 1'b0, a);
    accept(64'h8000_0006, 1'b1);
    check_eq("halt_fault", 64'(fetch_fault), 64'd0);
    check_eq("halt_cause", 64'(fault_cause), 64'd0);
    check_eq("halt_cnt", fetch_cnt, 64'd1);
    repeat (3) @(negedge clk);
    check_eq("halt_noreq", 64'(imem_req_valid), 64'd0);
    check_eq("halt_novalid", 64'(instr_valid), 64'd0);

    // Randomized episodes against the transaction model.
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      m_pc = RPC; m_cnt = 64'd0; m_term = 0; m_cause = 2'b00;
      m_req = 1'b1; m_valid = 1'b0; m_instr = 32'd0;
      waiting = 1'b0; lat = 0; post = 0; r_addr = RPC;
      for (int cyc = 0; cyc < 400 && post < 4; cyc++) begin
        logic fire_i, fire_r;
        fire_i = instr_ready && m_valid;
        fire_r = imem_req_ready && m_req;
        @(negedge clk);
        if (imem_rvalid) begin
          if (imem_rerr) begin
            m_term  = 2;
            m_cause = 2'b01;
          end else begin
            w       = mem_word({r_addr[63:3], 3'b000});
            m_valid = 1'b1;
            m_instr = r_addr[2] ? w[63:32] : w[31:0];
          end
          imem_rvalid = 1'b0;
          imem_rerr   = 1'b0;
        end
        if (fire_i) begin
          m_valid = 1'b0;
          m_cnt   = m_cnt + 64'd1;
          m_pc    = dnpc_i;
          if (halt_i) m_term = 1;
          else if (dnpc_i[1:0] != 2'b00) begin
            m_term  = 2;
            m_cause = 2'b10;
          end else m_req = 1'b1;
        end
        if (fire_r) begin
          m_req   = 1'b0;
          waiting = 1'b1;
          lat     = $urandom_range(0, 2);
          r_addr  = m_pc;
        end
        if (waiting) begin
          if (lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word({r_addr[63:3], 3'b000});
            imem_rerr   = ($urandom_range(0, 99) < 4);
            waiting     = 1'b0;
          end else lat--;
        end
        check_eq("rnd_req", 64'(imem_req_valid), 64'(m_req));
        if (m_req) check_eq("rnd_addr", imem_addr, {m_pc[63:3], 3'b000});
        check_eq("rnd_valid", 64'(instr_valid), 64'(m_valid));
        if (m_valid) check_eq("rnd_instr", 64'(instr_o), 64'(m_instr));
        check_eq("rnd_pc", pc_o, m_pc);
        check_eq("rnd_cnt", fetch_cnt, m_cnt);
        check_eq("rnd_fault", 64'(fetch_fault), 64'(m_term == 2));
        check_eq("rnd_cause", 64'(fault_cause), 64'(m_cause));
        if (m_term != 0) post++;
        imem_req_ready = ($urandom_range(0, 1) == 1);
        instr_ready    = ($urandom_range(0, 2) != 0);
        r = $urandom_range(0, 99);
        if (r < 4) dnpc_i = m_pc + (($urandom_range(0, 1) == 1) ? 64'd6 : 64'd2);
        else if (r < 25) dnpc_i = RPC + 64'($urandom_range(0, 255)) * 64'd4;
        else dnpc_i = m_pc + 64'd4;
        halt_i = ($urandom_range(0, 99) < 3);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
